flash_audio_sequencer: RTL and testbench
========================================

Name: flash_audio_sequencer

Overview:
- Sequences playback between the keyboard-driven address generator, the flash Avalon-MM read port, and the audio sample path.
- On each word: captures the current word address, issues one 32-bit flash read, and splits the word into two 16-bit samples.
- Emits one sample per `sample_tick`, with sample order set by play direction.
- After the second sample, pulses `addr_step` so the address generator advances exactly one step.

Parameters:
- ADDR_W, 23, flash word-address width.
- SETTLE_CYC, 2, cycles to wait after `addr_step` before sampling `word_addr`; minimum 1.
- TIMEOUT_CYC, 1024, read watchdog limit; used only with FLASH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-clk strobe at audio rate, already in the clk domain.
- play_en  in  1  1 = playing, 0 = paused (the address generator's idle output).
- direction  in  1  0 = forward, 1 = backward.
- word_addr  in  ADDR_W  current address from the address generator.
- addr_step  out  1  one-clk pulse; enable for the address generator to advance.
- flash_read  out  1  Avalon read request.
- flash_address  out  ADDR_W  Avalon word address.
- flash_byteenable  out  4  constant 4'hF.
- flash_waitrequest  in  1  Avalon waitrequest.
- flash_readdata  in  32  Avalon read data.
- flash_readdatavalid  in  1  Avalon read data valid.
- audio_data  out  16  current sample, held between updates.
- audio_valid  out  1  one-clk pulse when audio_data updates.
- busy  out  1  high in any state other than IDLE.
- flash_err  out  1  sticky timeout flag; present only with FLASH_TIMEOUT_EN.

Behaviour:
- Reset values: state IDLE; all outputs 0 except flash_byteenable = 4'hF. flash_address, audio_data and the word buffer are 0.
- Reset mid-read: flash_read drops in the same cycle. A late flash_readdatavalid seen in IDLE is ignored.
- FSM states: IDLE, SETTLE, REQ, WAIT_DATA, PLAY_A, PLAY_B.
- IDLE -> SETTLE when play_en = 1. The settle counter loads SETTLE_CYC.
- SETTLE: counter decrements each clk. At 0, latch flash_address <= word_addr and go to REQ.
- REQ: flash_read = 1 and flash_address stable. The read is accepted on the first cycle with flash_waitrequest = 0; then deassert flash_read and go to WAIT_DATA.
- WAIT_DATA: on flash_readdatavalid, latch flash_readdata and latch direction into dir_q, then go to PLAY_A.
- PLAY_A: on sample_tick, output the first sample, pulse audio_valid, go to PLAY_B.
  - dir_q = 0: first sample is readdata[15:0].
  - dir_q = 1: first sample is readdata[31:16].
- PLAY_B: on sample_tick, output the other half, pulse audio_valid and addr_step in the same cycle. Go to SETTLE if play_en = 1, else IDLE.
- Latency: sample output is registered; audio_valid is asserted in the clk after the sample_tick edge. Exactly one addr_step per word played; never in any other state.
- play_en = 0:
  - In SETTLE or PLAY_A/PLAY_B: go to IDLE next clk, no addr_step. audio_data holds; the remaining half-word is discarded.
  - In REQ or WAIT_DATA: the outstanding Avalon transaction completes (read accepted, data received), then IDLE.
  - While paused, the buffered word is discarded; resume refetches word_addr.
- Direction change mid-word: ignored until the next WAIT_DATA capture (dir_q latched per word).
- Wrap-around (0x7FFFF -> 0 forward, 0 -> 0x7FFFF backward) is the address generator's job. This block fetches whatever word_addr presents after settle.
- sample_tick during SETTLE, REQ or WAIT_DATA (fetch underrun): ignored. The pending sample plays on the next tick after data arrives.
- sample_tick coinciding with the readdatavalid cycle: not consumed; PLAY_A waits for the next tick.

Optional Feature:
- FLASH_TIMEOUT_EN
  - Defined:
    - A counter runs from REQ entry through WAIT_DATA.
    - On reaching TIMEOUT_CYC without readdatavalid: flash_read = 0, flash_err <= 1, go to IDLE.
    - flash_err is sticky until reset. New reads still proceed after a timeout.
  - Undefined: no counter and no flash_err port; REQ and WAIT_DATA wait indefinitely.

Decomposition:
- Package flash_audio_pkg holds:
  - the state enum (IDLE, SETTLE, REQ, WAIT_DATA, PLAY_A, PLAY_B);
  - localparams DIR_FWD = 1'b0, DIR_BWD = 1'b1;
  - SAMPLE_W = 16 and FLASH_DATA_W = 32.
- One natural sub-module: flash_read_timer. It holds the settle/timeout down-counter with load, decrement and zero flag. It is instantiated for SETTLE_CYC and, under FLASH_TIMEOUT_EN, for TIMEOUT_CYC.

Test Plan:
- Forward play: word_addr = 0x00010, readdata = 0xBEEF1234, 2-cycle waitrequest. Required: flash_address = 0x00010, exactly one accepted read, then audio_data 0x1234 then 0xBEEF on successive ticks. addr_step is high only on the 0xBEEF cycle.
- Backward play: same word with direction = 1 -> audio_data 0xBEEF then 0x1234; one addr_step.
- Pause in PLAY_B: play_en drops -> IDLE next clk, no audio_valid, no addr_step, audio_data holds 0x1234. Re-enable -> fresh read at the current word_addr.
- Pause during WAIT_DATA: play_en = 0 with read accepted. Required: no second read; state IDLE one clk after readdatavalid; no audio_valid.
- Reset mid-REQ: assert reset while flash_read = 1. Required: all outputs 0 next clk; a later readdatavalid = 1 with data 0xFFFFFFFF leaves audio_data = 0.
- FLASH_TIMEOUT_EN with TIMEOUT_CYC = 8: readdatavalid never asserted. Required: flash_err = 1 eight clks after REQ entry, busy = 0, flash_read = 0.

Source files
------------

// File: rtl/flash_audio_pkg.sv
// Shared types and constants for the flash audio sequencer: FSM state encoding,
// play-direction codes, sample/word widths and the half-word select helper.
package flash_audio_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETTLE    = 3'd1,
        REQ       = 3'd2,
        WAIT_DATA = 3'd3,
        PLAY_A    = 3'd4,
        PLAY_B    = 3'd5
    } state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_BWD = 1'b1;

    localparam int SAMPLE_W     = 16;
    localparam int FLASH_DATA_W = 32;

    // Forward plays the low half first; backward plays the high half first.
    function automatic logic [SAMPLE_W-1:0] sample_sel(
        input logic [FLASH_DATA_W-1:0] word,
        input logic                    dir,
        input logic                    second
    );
        logic upper;
        upper = second ? (dir == DIR_FWD) : (dir == DIR_BWD);
        return upper ? word[FLASH_DATA_W-1:SAMPLE_W] : word[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/flash_read_timer.sv
// Loadable down-counter used for the address settle delay and the read watchdog.
// o_last is high while the count is 1, i.e. the current decrement reaches zero.
module flash_read_timer #(
    parameter int CNT_W    = 4,
    parameter int LOAD_VAL = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_dec,
    output logic o_last
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(LOAD_VAL);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/flash_audio_sequencer.sv
// Fetches one 32-bit flash word per address step and plays it as two 16-bit
// samples on sample_tick. Optional read watchdog: define FLASH_TIMEOUT_EN.
module flash_audio_sequencer
    import flash_audio_pkg::*;
#(
    parameter int ADDR_W     = 23,
    parameter int SETTLE_CYC = 2
`ifdef FLASH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_tick,
    input  logic                    play_en,
    input  logic                    direction,
    input  logic [ADDR_W-1:0]       word_addr,
    output logic                    addr_step,
    output logic                    flash_read,
    output logic [ADDR_W-1:0]       flash_address,
    output logic [3:0]              flash_byteenable,
    input  logic                    flash_waitrequest,
    input  logic [FLASH_DATA_W-1:0] flash_readdata,
    input  logic                    flash_readdatavalid,
    output logic [SAMPLE_W-1:0]     audio_data,
    output logic                    audio_valid,
`ifdef FLASH_TIMEOUT_EN
    output logic                    flash_err,
`endif
    output logic                    busy
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [FLASH_DATA_W-1:0] r_word;
    logic                    r_dir;
    logic                    r_drop;
    logic                    w_set_last;
    logic                    w_take;
    logic                    w_timeout;

    assign flash_byteenable = 4'hF;

    flash_read_timer #(
        .CNT_W    (SET_W),
        .LOAD_VAL (SETTLE_CYC)
    ) u_settle_timer (
        .clk    (clk),
        .reset  (reset),
        .i_load ((w_next == SETTLE) && (r_state != SETTLE)),
        .i_dec  (r_state == SETTLE),
        .o_last (w_set_last)
    );

`ifdef FLASH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic w_to_last;

    flash_read_timer #(
        .CNT_W    (TO_W),
        .LOAD_VAL (TIMEOUT_CYC)
    ) u_timeout_timer (
        .clk    (clk),
        .reset  (reset),
        .i_load ((w_next == REQ) && (r_state != REQ)),
        .i_dec  ((r_state == REQ) || (r_state == WAIT_DATA)),
        .o_last (w_to_last)
    );

    // Data arriving on the last watchdog cycle still wins over the timeout.
    assign w_timeout = w_to_last && ((r_state == REQ) ||
                                     ((r_state == WAIT_DATA) && !flash_readdatavalid));

    always_ff @(posedge clk) begin
        if (reset) begin
            flash_err <= 1'b0;
        end else if (w_timeout) begin
            flash_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // A pause seen during the fetch aborts playback once the transaction ends.
    assign w_take = (r_state == WAIT_DATA) && flash_readdatavalid && play_en && !r_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (play_en) w_next = SETTLE;
            SETTLE:    if (!play_en) w_next = IDLE;
                       else if (w_set_last) w_next = REQ;
            REQ:       if (w_timeout) w_next = IDLE;
                       else if (!flash_waitrequest) w_next = WAIT_DATA;
            WAIT_DATA: if (flash_readdatavalid) w_next = w_take ? PLAY_A : IDLE;
                       else if (w_timeout) w_next = IDLE;
            PLAY_A:    if (!play_en) w_next = IDLE;
                       else if (sample_tick) w_next = PLAY_B;
            PLAY_B:    if (!play_en) w_next = IDLE;
                       else if (sample_tick) w_next = SETTLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != IDLE);
        flash_read = (r_state == REQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flash_address <= '0;
            audio_data    <= '0;
            audio_valid   <= 1'b0;
            addr_step     <= 1'b0;
            r_word        <= '0;
            r_dir         <= 1'b0;
            r_drop        <= 1'b0;
        end else begin
            audio_valid <= 1'b0;
            addr_step   <= 1'b0;
            if ((r_state == SETTLE) && (w_next == REQ)) begin
                flash_address <= word_addr;
            end
            if (w_take) begin
                r_word <= flash_readdata;
                r_dir  <= direction;
            end
            if ((r_state == PLAY_A) && (w_next == PLAY_B)) begin
                audio_data  <= sample_sel(r_word, r_dir, 1'b0);
                audio_valid <= 1'b1;
            end
            if ((r_state == PLAY_B) && (w_next == SETTLE)) begin
                audio_data  <= sample_sel(r_word, r_dir, 1'b1);
                audio_valid <= 1'b1;
                addr_step   <= 1'b1;
            end
            if (r_state == IDLE) begin
                r_drop <= 1'b0;
            end else if (((r_state == REQ) || (r_state == WAIT_DATA)) && !play_en) begin
                r_drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flash_audio_sequencer.sv
// Directed bench for flash_audio_sequencer with a small Avalon read-slave model
// driven from the same thread as the stimulus.
module tb_flash_audio_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_tick;
    logic        play_en;
    logic        direction;
    logic [22:0] word_addr;
    logic        addr_step;
    logic        flash_read;
    logic [22:0] flash_address;
    logic [3:0]  flash_byteenable;
    logic        flash_waitrequest;
    logic [31:0] flash_readdata;
    logic        flash_readdatavalid;
    logic [15:0] audio_data;
    logic        audio_valid;
    logic        busy;
`ifdef FLASH_TIMEOUT_EN
    logic        flash_err;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_acc   = 0;
    int   n_valid = 0;
    int   n_step  = 0;
    int   ws_cfg  = 0;
    int   ws_left = 0;
    int   rdv_lat = 1;
    int   pend    = 0;
    logic rdv_en    = 1'b1;
    logic rdv_force = 1'b0;
    int   base_acc, base_valid, base_step;

    always #5 clk = ~clk;

    flash_audio_sequencer #(
        .ADDR_W     (23),
        .SETTLE_CYC (2)
`ifdef FLASH_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(8)
`endif
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .sample_tick         (sample_tick),
        .play_en             (play_en),
        .direction           (direction),
        .word_addr           (word_addr),
        .addr_step           (addr_step),
        .flash_read          (flash_read),
        .flash_address       (flash_address),
        .flash_byteenable    (flash_byteenable),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdata      (flash_readdata),
        .flash_readdatavalid (flash_readdatavalid),
        .audio_data          (audio_data),
        .audio_valid         (audio_valid),
`ifdef FLASH_TIMEOUT_EN
        .flash_err           (flash_err),
`endif
        .busy                (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: observe outputs 1 ns after the edge, then update the slave model.
    task automatic cyc();
        logic acc;
        acc = flash_read && !flash_waitrequest && !reset;
        @(posedge clk);
        #1;
        if (audio_valid) n_valid++;
        if (addr_step)   n_step++;
        if (acc) begin
            n_acc++;
            pend    = rdv_lat;
            ws_left = ws_cfg;
        end
        flash_readdatavalid = rdv_force;
        if (pend > 0) begin
            pend--;
            if (pend == 0) flash_readdatavalid = rdv_en | rdv_force;
        end
        flash_waitrequest = flash_read && (ws_left > 0);
        if (flash_waitrequest) ws_left--;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
    endtask

    task automatic wait_acc(input int target);
        int k;
        k = 0;
        while (n_acc < target && k < 100) begin
            cyc();
            k++;
        end
        chk("read_accepted", n_acc, target);
    endtask

    initial begin
        reset = 1'b1; sample_tick = 1'b0; play_en = 1'b0; direction = 1'b0;
        word_addr = '0; flash_waitrequest = 1'b0; flash_readdata = '0;
        flash_readdatavalid = 1'b0;
        repeat (3) cyc();
        chk("rst_busy", busy, 0);
        chk("rst_read", flash_read, 0);
        chk("rst_byteen", flash_byteenable, 4'hF);
        chk("rst_audio", audio_data, 0);
        chk("rst_addr", flash_address, 0);
        reset = 1'b0;
        cyc();

        // Forward play with two waitrequest cycles
        word_addr = 23'h10; flash_readdata = 32'hBEEF1234; ws_cfg = 2; ws_left = 2;
        rdv_lat = 1; play_en = 1'b1; base_acc = n_acc;
        wait_acc(base_acc + 1);
        chk("fwd_addr", flash_address, 23'h10);
        cyc();
        chk("fwd_busy", busy, 1);
        base_step = n_step;
        tick();
        chk("fwd_s0_valid", audio_valid, 1);
        chk("fwd_s0_data", audio_data, 16'h1234);
        chk("fwd_s0_step", addr_step, 0);
        tick();
        chk("fwd_s1_data", audio_data, 16'hBEEF);
        chk("fwd_s1_step", addr_step, 1);
        chk("fwd_one_read", n_acc, base_acc + 1);
        play_en = 1'b0;
        cyc();
        chk("fwd_step_cnt", n_step, base_step + 1);
        chk("fwd_idle", busy, 0);

        // Backward play; tick on the data cycle is not consumed; direction flips mid-word
        direction = 1'b1; ws_cfg = 0; ws_left = 0; play_en = 1'b1; base_acc = n_acc;
        wait_acc(base_acc + 1);
        base_valid = n_valid;
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        chk("bwd_tick_on_rdv", n_valid, base_valid);
        direction = 1'b0;
        tick();
        chk("bwd_s0_data", audio_data, 16'hBEEF);
        tick();
        chk("bwd_s1_data", audio_data, 16'h1234);
        chk("bwd_s1_step", addr_step, 1);
        play_en = 1'b0;
        cyc();

        // Pause in PLAY_B, then resume from a new address
        play_en = 1'b1; base_acc = n_acc;
        wait_acc(base_acc + 1);
        cyc();
        tick();
        chk("pause_s0_data", audio_data, 16'h1234);
        play_en = 1'b0;
        cyc();
        chk("pause_idle", busy, 0);
        base_valid = n_valid; base_step = n_step;
        tick();
        chk("pause_no_valid", n_valid, base_valid);
        chk("pause_no_step", n_step, base_step);
        chk("pause_hold", audio_data, 16'h1234);
        word_addr = 23'h20; flash_readdata = 32'hCAFE5678; play_en = 1'b1;
        wait_acc(base_acc + 2);
        chk("resume_addr", flash_address, 23'h20);
        cyc();
        tick();
        chk("resume_s0_data", audio_data, 16'h5678);
        play_en = 1'b0;
        cyc();

        // Pause while waiting for read data
        rdv_lat = 3; play_en = 1'b1; base_acc = n_acc; base_valid = n_valid;
        wait_acc(base_acc + 1);
        play_en = 1'b0;
        cyc();
        cyc();
        chk("wpause_rdv", flash_readdatavalid, 1);
        chk("wpause_busy", busy, 1);
        cyc();
        chk("wpause_idle", busy, 0);
        tick();
        tick();
        chk("wpause_no_valid", n_valid, base_valid);
        chk("wpause_one_read", n_acc, base_acc + 1);
        rdv_lat = 1;

        // Reset while the read request is stalled
        word_addr = 23'h30; ws_cfg = 5; ws_left = 5; play_en = 1'b1;
        for (int k = 0; k < 50 && !flash_read; k++) cyc();
        chk("rreq_seen", flash_read, 1);
        reset = 1'b1; play_en = 1'b0;
        cyc();
        chk("rreq_read", flash_read, 0);
        chk("rreq_busy", busy, 0);
        chk("rreq_addr", flash_address, 0);
        chk("rreq_audio", audio_data, 0);
        reset = 1'b0; flash_readdata = 32'hFFFFFFFF; rdv_force = 1'b1;
        cyc();
        rdv_force = 1'b0;
        base_valid = n_valid;
        cyc();
        tick();
        chk("rreq_late_valid", n_valid, base_valid);
        chk("rreq_late_audio", audio_data, 0);

`ifdef FLASH_TIMEOUT_EN
        // Watchdog: data never returns
        ws_cfg = 0; ws_left = 0; rdv_en = 1'b0; play_en = 1'b1;
        for (int k = 0; k < 50 && !flash_read; k++) cyc();
        chk("to_req_seen", flash_read, 1);
        repeat (7) cyc();
        chk("to_err_early", flash_err, 0);
        chk("to_busy_early", busy, 1);
        cyc();
        chk("to_err", flash_err, 1);
        chk("to_busy", busy, 0);
        chk("to_read", flash_read, 0);
        rdv_en = 1'b1; base_acc = n_acc;
        wait_acc(base_acc + 1);
        play_en = 1'b0;
        repeat (3) cyc();
        chk("to_err_sticky", flash_err, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
